// File: rtl/slc_cfg_pkg.sv
// Shared types and constants for the super-logic-cell configuration loader.
// Holds the loader state encoding and the bit layout of the 24-bit per-cell word.
package slc_cfg_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StCheck,
      StCommit,
      StError
   } state_e;

   localparam logic [7:0] HDR = 8'hA5;

   localparam int unsigned LUT_LSB      = 0;
   localparam int unsigned MODE_BIT     = 16;
   localparam int unsigned QDI_LSB      = 17;
   localparam int unsigned BQZ_BIT      = 19;
   localparam int unsigned CQZ_BIT      = 20;
   localparam int unsigned BYTES_PER_LC = 3;

endpackage

// File: rtl/slc_config_loader_if.sv
// Byte-serial configuration stream: valid/ready handshake plus an abort strobe.
// The master drives bytes toward the loader, which is the slave.
interface slc_config_loader_if;
   logic [7:0] cfg_data;
   logic       cfg_valid;
   logic       cfg_ready;
   logic       cfg_abort;

   modport master (
      output cfg_data,
      output cfg_valid,
      output cfg_abort,
      input  cfg_ready
   );

   modport slave (
      input  cfg_data,
      input  cfg_valid,
      input  cfg_abort,
      output cfg_ready
   );
endinterface

// File: rtl/slc_cfg_unpack.sv
// Combinational split of the packed active configuration into per-field buses.
// Cell k owns word bits [24k+23:24k]; bits [23:21] of each word are reserved.
module slc_cfg_unpack
   import slc_cfg_pkg::*;
#(
   parameter int unsigned NUM_LC = 8,
   parameter int unsigned LUT_W  = 16
) (
   input  logic [8*BYTES_PER_LC*NUM_LC-1:0] active,
   output logic [NUM_LC*LUT_W-1:0]          lut_init,
   output logic [NUM_LC-1:0]                lc_mode,
   output logic [2*NUM_LC-1:0]              lc_qdi_mux,
   output logic [NUM_LC-1:0]                lc_bqz_mux,
   output logic [NUM_LC-1:0]                lc_cqz_mux
);

   localparam int unsigned WordW = 8 * BYTES_PER_LC;

   logic [NUM_LC-1:0] unused_rsvd;

   for (genvar k = 0; k < NUM_LC; k++) begin : g_cell
      assign lut_init[k*LUT_W +: LUT_W] = active[k*WordW + LUT_LSB +: LUT_W];
      assign lc_mode[k]                 = active[k*WordW + MODE_BIT];
      assign lc_qdi_mux[2*k +: 2]       = active[k*WordW + QDI_LSB +: 2];
      assign lc_bqz_mux[k]              = active[k*WordW + BQZ_BIT];
      assign lc_cqz_mux[k]              = active[k*WordW + CQZ_BIT];
      assign unused_rsvd[k]             = ^active[k*WordW + CQZ_BIT + 1 +: WordW - CQZ_BIT - 1];
   end

endmodule

// File: rtl/slc_config_loader.sv
// Loads a checksummed byte-serial frame into a shadow buffer and commits it atomically,
// so the logic cells only ever see a fully verified configuration.
module slc_config_loader #(
   parameter int unsigned NUM_LC = 8,
   parameter int unsigned LUT_W  = 16,
   parameter logic [7:0]  HDR    = slc_cfg_pkg::HDR
) (
   input  logic                      QCK,
   input  logic                      QRTN,
   slc_config_loader_if.slave        cfg,
   output logic [NUM_LC*LUT_W-1:0]   lut_init,
   output logic [NUM_LC-1:0]         lc_mode,
   output logic [2*NUM_LC-1:0]       lc_qdi_mux,
   output logic [NUM_LC-1:0]         lc_bqz_mux,
   output logic [NUM_LC-1:0]         lc_cqz_mux,
   output logic                      cfg_done,
   output logic                      cfg_err,
   output logic                      cfg_loaded,
   output logic                      cfg_bad
);
   import slc_cfg_pkg::*;

   localparam int unsigned NumBytes = BYTES_PER_LC * NUM_LC;
   localparam int unsigned CntW     = $clog2(NumBytes);
   localparam int unsigned VecW     = 8 * NumBytes;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [7:0]        csum_q, csum_d;
   logic [VecW-1:0]   shadow_q;
   logic [VecW-1:0]   active_q;
   logic              loaded_q, bad_q;
   logic              shadow_we;
   logic              ready;
   logic              xfer;

   assign ready = QRTN && (state_q == StIdle || state_q == StLoad || state_q == StCheck);
   assign xfer  = cfg.cfg_valid && ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      csum_d    = csum_q;
      shadow_we = 1'b0;
      case (state_q)
         StIdle: begin
            if (xfer && cfg.cfg_data == HDR) begin
               state_d = StLoad;
               cnt_d   = '0;
               csum_d  = '0;
            end
         end
         StLoad: begin
            if (xfer) begin
               shadow_we = 1'b1;
               csum_d    = csum_q ^ cfg.cfg_data;
               cnt_d     = cnt_q + CntW'(1);
               if (cnt_q == CntW'(NumBytes - 1)) state_d = StCheck;
            end
         end
         StCheck: begin
            if (xfer) state_d = (cfg.cfg_data == csum_q) ? StCommit : StError;
         end
         StCommit: state_d = StIdle;
         StError:  state_d = StIdle;
         default:  state_d = StIdle;
      endcase
      // Abort wins over a same-cycle transfer; a commit already in COMMIT still lands.
      if (cfg.cfg_abort) begin
         state_d   = StIdle;
         cnt_d     = '0;
         csum_d    = '0;
         shadow_we = 1'b0;
      end
   end

   always_ff @(posedge QCK) begin
      if (!QRTN) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         csum_q   <= '0;
         active_q <= '0;
         loaded_q <= 1'b0;
         bad_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         csum_q  <= csum_d;
         if (state_q == StCommit) begin
            active_q <= shadow_q;
            loaded_q <= 1'b1;
            bad_q    <= 1'b0;
         end
         if (state_q == StError) bad_q <= 1'b1;
      end
   end

   // Shadow contents are meaningless until a full frame lands, so no reset.
   always_ff @(posedge QCK) begin
      if (shadow_we) shadow_q[{cnt_q, 3'b000} +: 8] <= cfg.cfg_data;
   end

   assign cfg.cfg_ready = ready;
   assign cfg_done      = QRTN && (state_q == StCommit);
   assign cfg_err       = QRTN && (state_q == StError);
   assign cfg_loaded    = loaded_q;
   assign cfg_bad       = bad_q;

   slc_cfg_unpack #(
      .NUM_LC (NUM_LC),
      .LUT_W  (LUT_W)
   ) u_unpack (
      .active     (active_q),
      .lut_init   (lut_init),
      .lc_mode    (lc_mode),
      .lc_qdi_mux (lc_qdi_mux),
      .lc_bqz_mux (lc_bqz_mux),
      .lc_cqz_mux (lc_cqz_mux)
   );

endmodule
